fp_norm_128: RTL

// - 2-stage pipelined normaliser directly downstream of lzc_128 (instantiated inside).
// - Takes a raw 128-bit mantissa + signed exponent from the adder/multiplier datapath, counts

---
 rtl/fp_norm_128.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_norm_128.sv
// fp_norm_128: two-stage pipelined mantissa normaliser.
//   S1 captures the incoming beat together with its leading-zero count.
//   S2 left-shifts the mantissa so bit 127 is set and lowers the exponent by the
//   same amount.
//   lzc_128, the leading-zero counter, lives in this file.
//
// Optional build macro NORM_SUBNORM_CLAMP_EN:
//   When it is defined, the shift is limited so the exponent never drops below 1.
//   Such a result stays subnormal, with bit 127 clear.
//   When it is undefined, the shift always equals the leading-zero count.

// lzc_128: leading-zero count of a 128-bit word.
// count is 0 when bit 127 is set. valid is low when data is all zero, and count is
// then 0.
module lzc_128 (
    input  logic [127:0] data,
    output logic [6:0]   count,
    output logic         valid
);

    logic [7:0] grp_nz;
    logic [3:0] grp_cnt [8];

    // Per 16-bit group: a nonzero flag and a local leading-zero count
    // (the highest set bit wins).
    always_comb begin
        for (int g = 0; g < 8; g++) begin
            grp_nz[g]  = |data[g*16 +: 16];
            grp_cnt[g] = 4'd0;
            for (int b = 0; b < 16; b++) begin
                if (data[g*16 + b]) begin
                    grp_cnt[g] = 4'(15 - b);
                end
            end
        end
    end

    // Pick the most significant nonzero group.
    // Its index gives the upper count bits.
    always_comb begin
        count = 7'd0;
        valid = |grp_nz;
        for (int g = 0; g < 8; g++) begin
            if (grp_nz[g]) begin
                count = {3'(7 - g), grp_cnt[g]};
            end
        end
    end

endmodule

// Handshake: a beat moves across a port on a rising clock edge when valid and ready
// are both high.
//   - valid never depends on ready.
//   - A stage holding a beat keeps every register stable until that beat is taken.
//   - in_ready is combinational from out_ready; there is no skid buffer.
module fp_norm_128 #(
    parameter int EXP_W = 18,
    parameter int TAG_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_mant,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    // Stage 1 registers
    logic             s1_valid;
    logic [127:0]     s1_mant;
    logic [EXP_W-1:0] s1_exp;
    logic [TAG_W-1:0] s1_tag;
    logic [6:0]       s1_shift;
    logic             s1_nz;

    // Stage 2 registers (drive out_* directly)
    logic             s2_valid;
    logic [127:0]     s2_mant;
    logic [EXP_W-1:0] s2_exp;
    logic             s2_zero;
    logic [TAG_W-1:0] s2_tag;

    logic             s2_ready;
    logic [6:0]       lz_cnt;
    logic             lz_nz;
    logic [6:0]       shift_next;
    logic [127:0]     mant_next;
    logic [EXP_W-1:0] exp_next;

    lzc_128 u_lzc (
        .data  (in_mant),
        .count (lz_cnt),
        .valid (lz_nz)
    );

    // Pipeline flow control.
    // A stage may load when it is empty or when its content leaves this cycle.
    always_comb begin
        s2_ready = ~s2_valid | out_ready;
        in_ready = ~s1_valid | s2_ready;
    end

`ifdef NORM_SUBNORM_CLAMP_EN
    localparam logic signed [EXP_W:0]   ONE_WIDE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic signed [EXP_W-1:0] ONE_EXP  = {{(EXP_W-1){1'b0}}, 1'b1};

    logic signed [EXP_W-1:0] exp_s;
    logic signed [EXP_W:0]   exp_wide;
    logic signed [EXP_W:0]   diff_wide;

    // Clamped shift, chosen in S1.
    //   - A full shift must leave the exponent >= 1.
    //   - Otherwise shift only down to exponent 1; if the exponent is already <= 1, do not shift.
    // The difference uses one extra bit, so a very negative exponent cannot wrap and
    // pass the test.
    always_comb begin
        exp_s     = $signed(in_exp);
        exp_wide  = $signed({in_exp[EXP_W-1], in_exp});
        diff_wide = exp_wide - $signed({{(EXP_W-6){1'b0}}, lz_cnt});
        if (diff_wide >= ONE_WIDE) begin
            shift_next = lz_cnt;
        end else if (exp_s > ONE_EXP) begin
            shift_next = 7'(exp_s - ONE_EXP);
        end else begin
            shift_next = 7'd0;
        end
    end
`else
    // Unclamped: shift by the full leading-zero count.
    // The exponent may reach zero or go negative.
    always_comb begin
        shift_next = lz_cnt;
    end
`endif

    // Stage 1: capture the accepted beat and its shift amount.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_tag   <= '0;
            s1_shift <= '0;
            s1_nz    <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_mant  <= in_mant;
                s1_exp   <= in_exp;
                s1_tag   <= in_tag;
                s1_shift <= shift_next;
                s1_nz    <= lz_nz;
            end
        end
    end

    // Shift and exponent adjust.
    // An all-zero mantissa gives mant = 0 and exp = 0.
    // The exponent subtraction wraps in EXP_W bits.
    always_comb begin
        if (s1_nz) begin
            mant_next = s1_mant << s1_shift;
            exp_next  = s1_exp - {{(EXP_W-7){1'b0}}, s1_shift};
        end else begin
            mant_next = '0;
            exp_next  = '0;
        end
    end

    // Stage 2: register the normalised result.
    // Hold it while downstream stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_mant  <= '0;
            s2_exp   <= '0;
            s2_zero  <= 1'b0;
            s2_tag   <= '0;
        end else begin
            if (s2_ready) begin
                s2_valid <= s1_valid;
            end
            if (s1_valid && s2_ready) begin
                s2_mant <= mant_next;
                s2_exp  <= exp_next;
                s2_zero <= ~s1_nz;
                s2_tag  <= s1_tag;
            end
        end
    end

    // Output drive
    always_comb begin
        out_valid = s2_valid;
        out_mant  = s2_mant;
        out_exp   = s2_exp;
        out_zero  = s2_zero;
        out_tag   = s2_tag;
    end

endmodule
